// File: rtl/mult_acc_stage.sv
// Accumulates groups of multiplier products (delimited by prod_last) and presents sum/count/overflow via valid/ready.
// Optional build macro MULT_ACC_SATURATE_EN: clamp the running sum to all-ones on overflow instead of wrapping.
module mult_acc_stage #(
  parameter int PROD_W = 17,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  logic [ACC_W-1:0] run_sum_q, run_sum_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_ovf_q, run_ovf_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             acc_valid_q, acc_valid_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_inc;

  assign prod_ready = !acc_valid_q || acc_ready;
  assign accept     = prod_valid && prod_ready;

  always_comb begin
    sum_ext = {1'b0, run_sum_q} + {1'b0, {(ACC_W-PROD_W){1'b0}}, prod_in};
    carry   = sum_ext[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
    // Once the true sum has exceeded the range the group stays pinned at all-ones.
    sum_next = (carry || run_ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum_next = sum_ext[ACC_W-1:0];
`endif
    cnt_inc = (run_cnt_q == {CNT_W{1'b1}}) ? run_cnt_q : run_cnt_q + CNT_W'(1);
  end

  always_comb begin
    run_sum_d   = run_sum_q;
    run_cnt_d   = run_cnt_q;
    run_ovf_d   = run_ovf_q;
    acc_out_d   = acc_out_q;
    acc_count_d = acc_count_q;
    acc_ovf_d   = acc_ovf_q;
    acc_valid_d = acc_valid_q;

    if (acc_valid_q && acc_ready) begin
      acc_valid_d = 1'b0;
    end

    if (clear) begin
      // Flush wins over any beat handshaken this cycle; the beat is dropped.
      run_sum_d   = '0;
      run_cnt_d   = '0;
      run_ovf_d   = 1'b0;
      acc_valid_d = 1'b0;
    end else if (accept) begin
      if (prod_last) begin
        acc_out_d   = sum_next;
        acc_count_d = cnt_inc;
        acc_ovf_d   = run_ovf_q || carry;
        acc_valid_d = 1'b1;
        run_sum_d   = '0;
        run_cnt_d   = '0;
        run_ovf_d   = 1'b0;
      end else begin
        run_sum_d = sum_next;
        run_cnt_d = cnt_inc;
        run_ovf_d = run_ovf_q || carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sum_q   <= '0;
      run_cnt_q   <= '0;
      run_ovf_q   <= 1'b0;
      acc_out_q   <= '0;
      acc_count_q <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      run_sum_q   <= run_sum_d;
      run_cnt_q   <= run_cnt_d;
      run_ovf_q   <= run_ovf_d;
      acc_out_q   <= acc_out_d;
      acc_count_q <= acc_count_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_count = acc_count_q;
  assign acc_ovf   = acc_ovf_q;
  assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Scoreboard bench for mult_acc_stage: directed groups push expected results, a monitor checks each output transfer.
module tb_mult_acc_stage;

  localparam int PROD_W = 17;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PROD_W-1:0] prod_in = '0;
  logic              prod_valid = 1'b0;
  logic              prod_last = 1'b0;
  logic              prod_ready;
  logic              clear = 1'b0;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;
  logic              acc_valid;
  logic              acc_ready = 1'b1;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  res_t exp_q[$];
  int checks = 0;
  int failures = 0;

  mult_acc_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .clear(clear),
    .acc_out(acc_out), .acc_count(acc_count), .acc_ovf(acc_ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic res_t mk(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic o);
    res_t r;
    r.sum = s; r.cnt = c; r.ovf = o;
    return r;
  endfunction

  // Monitor: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got sum=0x%0h cnt=%0d with empty scoreboard", acc_out, acc_count);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result_sum", 32'(acc_out), 32'(e.sum));
        chk("result_cnt", 32'(acc_count), 32'(e.cnt));
        chk("result_ovf", 32'(acc_ovf), 32'(e.ovf));
      end
    end
  end

  // Present one beat and hold it until the handshake edge (bounded).
  task automatic beat(input logic [PROD_W-1:0] p, input logic last);
    bit done;
    done = 1'b0;
    prod_in = p; prod_valid = 1'b1; prod_last = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (prod_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: prod_ready stayed 0 expected 1");
    end
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_acc_out", 32'(acc_out), 0);
    chk("rst_acc_count", 32'(acc_count), 0);
    chk("rst_acc_ovf", 32'(acc_ovf), 0);
    chk("rst_acc_valid", 32'(acc_valid), 0);
    #10 rst_n = 1'b1;
    cyc();
    chk("rst_prod_ready", 32'(prod_ready), 1);

    // Basic group 100+200+300
    exp_q.push_back(mk(24'd600, 8'd3, 1'b0));
    beat(17'd100, 1'b0);
    beat(17'd200, 1'b0);
    beat(17'd300, 1'b1);
    chk("basic_latency_valid", 32'(acc_valid), 1);
    cyc();

    // Single full-scale beat; valid lasts one cycle with ready held
    exp_q.push_back(mk(24'h01FFFF, 8'd1, 1'b0));
    beat(17'h1FFFF, 1'b1);
    chk("single_valid", 32'(acc_valid), 1);
    cyc();
    chk("single_valid_drop", 32'(acc_valid), 0);

    // Backpressure: result 5 held for 5 cycles while beat 7 waits
    acc_ready = 1'b0;
    exp_q.push_back(mk(24'd5, 8'd1, 1'b0));
    beat(17'd5, 1'b1);
    prod_in = 17'd7; prod_valid = 1'b1; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_prod_ready", 32'(prod_ready), 0);
      chk("bp_hold_out", 32'(acc_out), 5);
      chk("bp_hold_cnt", 32'(acc_count), 1);
      @(posedge clk); #1;
    end
    exp_q.push_back(mk(24'd7, 8'd1, 1'b0));
    acc_ready = 1'b1;
    cyc();
    prod_valid = 1'b0; prod_last = 1'b0;
    chk("b2b_valid", 32'(acc_valid), 1);
    chk("b2b_out", 32'(acc_out), 7);
    cyc();

    // Overflow: 129 beats of 0x1FFFF
`ifdef MULT_ACC_SATURATE_EN
    exp_q.push_back(mk(24'hFFFFFF, 8'd129, 1'b1));
`else
    exp_q.push_back(mk(24'd130943, 8'd129, 1'b1));
`endif
    for (int i = 0; i < 128; i++) beat(17'h1FFFF, 1'b0);
    beat(17'h1FFFF, 1'b1);
    cyc();

    // Beat counter saturation: 300 zero beats
    exp_q.push_back(mk(24'd0, 8'd255, 1'b0));
    for (int i = 0; i < 299; i++) beat(17'd0, 1'b0);
    beat(17'd0, 1'b1);
    cyc();

    // clear mid-group discards partial sum and concurrent beat
    exp_q.push_back(mk(24'd30, 8'd2, 1'b0));
    beat(17'd50, 1'b0);
    beat(17'd50, 1'b0);
    clear = 1'b1; prod_in = 17'd999; prod_valid = 1'b1; prod_last = 1'b1;
    cyc();
    clear = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
    chk("clear_no_valid", 32'(acc_valid), 0);
    beat(17'd10, 1'b0);
    beat(17'd20, 1'b1);
    cyc();

    // clear while a result is held: valid drops, data retained
    acc_ready = 1'b0;
    beat(17'd77, 1'b1);
    chk("held_valid", 32'(acc_valid), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear_held_valid", 32'(acc_valid), 0);
    chk("clear_held_out", 32'(acc_out), 77);
    acc_ready = 1'b1;
    cyc();

    // Asynchronous reset while holding a result
    acc_ready = 1'b0;
    beat(17'd9, 1'b1);
    chk("pre_arst_valid", 32'(acc_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc_valid", 32'(acc_valid), 0);
    chk("arst_acc_out", 32'(acc_out), 0);
    chk("arst_acc_count", 32'(acc_count), 0);
    chk("arst_acc_ovf", 32'(acc_ovf), 0);
    #10 rst_n = 1'b1;
    cyc();
    chk("arst_prod_ready", 32'(prod_ready), 1);
    acc_ready = 1'b1;

    repeat (3) cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
